// File: rtl/string_handle_allocator_if.sv
// Handshake bundle between string-producing logic and the handle allocator.
interface string_handle_allocator_if #(
    parameter int HANDLE_WIDTH = 6,
    parameter int REF_WIDTH    = 8
);
    logic                    alloc_req;
    logic                    alloc_ready;
    logic [HANDLE_WIDTH-1:0] alloc_handle;
    logic                    adj_valid;
    logic [HANDLE_WIDTH-1:0] adj_handle;
    logic [REF_WIDTH:0]      adj_amount;
    logic                    free_valid;
    logic [HANDLE_WIDTH-1:0] free_handle;
    logic [HANDLE_WIDTH-1:0] num_live;
    logic                    error;

    modport master (
        output alloc_req, adj_valid, adj_handle, adj_amount,
        input  alloc_ready, alloc_handle, free_valid, free_handle, num_live, error
    );

    modport slave (
        input  alloc_req, adj_valid, adj_handle, adj_amount,
        output alloc_ready, alloc_handle, free_valid, free_handle, num_live, error
    );
endinterface

// File: rtl/string_handle_allocator.sv
// Issues nonzero string handles from a free-list FIFO, tracks per-handle
// reference counts and recycles a handle one cycle after its count hits zero.
module string_handle_allocator #(
    parameter int HANDLE_WIDTH = 6,
    parameter int REF_WIDTH    = 8
) (
    input logic                       clk,
    input logic                       rst,
    string_handle_allocator_if.slave  bus
);
    localparam int                    DEPTH   = 1 << HANDLE_WIDTH;
    localparam logic [HANDLE_WIDTH-1:0] LAST_H  = '1;
    localparam logic [REF_WIDTH-1:0]    REF_MAX = '1;
    localparam logic [HANDLE_WIDTH:0]   FULL    = (HANDLE_WIDTH+1)'(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [HANDLE_WIDTH-1:0] init_cnt_q, init_cnt_d;

    logic [HANDLE_WIDTH-1:0] fifo_mem [DEPTH];
    logic [HANDLE_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
    logic [HANDLE_WIDTH:0]   occ_q;

    logic [REF_WIDTH-1:0]    ref_mem [DEPTH];
    logic [DEPTH-1:0]        live_q;

    logic                    pend_valid_q;
    logic [HANDLE_WIDTH-1:0] pend_handle_q;
    logic [HANDLE_WIDTH-1:0] num_live_q;
    logic                    error_q;

    logic                    push, pop, fifo_full;
    logic [HANDLE_WIDTH-1:0] push_data, head;
    logic                    adj_hit, adj_apply, adj_zero, underflow, overflow, err_set;
    logic signed [REF_WIDTH+1:0] cur_ext, amt_ext, sum;
    logic [REF_WIDTH-1:0]    adj_result;

    // State register and init counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= HANDLE_WIDTH'(1);
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state and FIFO push source: init sweep, then pending releases
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        push       = 1'b0;
        push_data  = '0;
        if (state_q == ST_INIT) begin
            push       = 1'b1;
            push_data  = init_cnt_q;
            init_cnt_d = init_cnt_q + HANDLE_WIDTH'(1);
            if (init_cnt_q == LAST_H) state_d = ST_RUN;
        end else if (pend_valid_q) begin
            push      = 1'b1;
            push_data = pend_handle_q;
        end
    end

    // Grant path and reference-count adjustment arithmetic
    always_comb begin
        head       = fifo_mem[rd_ptr_q];
        fifo_full  = (occ_q == FULL);
        pop        = bus.alloc_req && bus.alloc_ready;
        adj_hit    = (state_q == ST_RUN) && bus.adj_valid && (bus.adj_handle != '0);
        adj_apply  = adj_hit && live_q[bus.adj_handle];
        cur_ext    = $signed({2'b00, ref_mem[bus.adj_handle]});
        amt_ext    = $signed({bus.adj_amount[REF_WIDTH], bus.adj_amount});
        sum        = cur_ext + amt_ext;
        underflow  = sum[REF_WIDTH+1];
        overflow   = !sum[REF_WIDTH+1] && sum[REF_WIDTH];
        adj_result = underflow ? '0 : (overflow ? REF_MAX : sum[REF_WIDTH-1:0]);
        adj_zero   = adj_apply && (adj_result == '0);
        err_set    = (adj_hit && !live_q[bus.adj_handle])
                   || (adj_apply && (underflow || overflow))
                   || (push && fifo_full);
    end

    // FIFO pointers, live bits, pending release, live count and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            occ_q         <= '0;
            live_q        <= '0;
            pend_valid_q  <= 1'b0;
            pend_handle_q <= '0;
            num_live_q    <= '0;
            error_q       <= 1'b0;
        end else begin
            if (push && !fifo_full) wr_ptr_q <= wr_ptr_q + HANDLE_WIDTH'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + HANDLE_WIDTH'(1);
            if (push && !fifo_full && !pop) occ_q <= occ_q + (HANDLE_WIDTH+1)'(1);
            else if (pop && !(push && !fifo_full)) occ_q <= occ_q - (HANDLE_WIDTH+1)'(1);
            if (pop) live_q[head] <= 1'b1;
            if (adj_zero) live_q[bus.adj_handle] <= 1'b0;
            pend_valid_q  <= adj_zero;
            pend_handle_q <= adj_zero ? bus.adj_handle : '0;
            if (pop && !adj_zero) num_live_q <= num_live_q + HANDLE_WIDTH'(1);
            else if (adj_zero && !pop) num_live_q <= num_live_q - HANDLE_WIDTH'(1);
            if (err_set) error_q <= 1'b1;
        end
    end

    // Unreset storage: free-list entries and reference counts, gated by live bits
    always_ff @(posedge clk) begin
        if (push && !fifo_full) fifo_mem[wr_ptr_q] <= push_data;
        if (pop) ref_mem[head] <= REF_WIDTH'(1);
        if (adj_apply) ref_mem[bus.adj_handle] <= adj_result;
    end

    assign bus.alloc_ready  = (state_q == ST_RUN) && (occ_q != '0);
    assign bus.alloc_handle = bus.alloc_ready ? head : '0;
    assign bus.free_valid   = pend_valid_q;
    assign bus.free_handle  = pend_handle_q;
    assign bus.num_live     = num_live_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_string_handle_allocator.sv
// Directed bench for the string handle allocator.
module tb_string_handle_allocator;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    string_handle_allocator_if #(.HANDLE_WIDTH(6), .REF_WIDTH(8)) bus ();

    string_handle_allocator #(.HANDLE_WIDTH(6), .REF_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (63) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.alloc_req  = 1'b0;
        bus.adj_valid  = 1'b0;
        bus.adj_handle = '0;
        bus.adj_amount = '0;
    endtask

    task automatic set_adj(input logic [5:0] h, input logic signed [8:0] amt);
        bus.adj_valid  = 1'b1;
        bus.adj_handle = h;
        bus.adj_amount = amt;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();

        // Reset values
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(bus.alloc_ready), 0);
        check_val("rst_handle", 32'(bus.alloc_handle), 0);
        check_val("rst_free_valid", 32'(bus.free_valid), 0);
        check_val("rst_free_handle", 32'(bus.free_handle), 0);
        check_val("rst_num_live", 32'(bus.num_live), 0);
        check_val("rst_error", 32'(bus.error), 0);

        // Init sweep takes 63 cycles; alloc_req ignored during it
        rst = 1'b0;
        bus.alloc_req = 1'b1;
        repeat (62) @(negedge clk);
        check_val("init_ready_62", 32'(bus.alloc_ready), 0);
        check_val("init_live_62", 32'(bus.num_live), 0);
        @(negedge clk);
        check_val("init_ready_63", 32'(bus.alloc_ready), 1);

        // Three back-to-back grants
        for (int unsigned i = 1; i <= 3; i++) begin
            check_val("grant_seq", 32'(bus.alloc_handle), 32'(i));
            @(negedge clk);
        end
        bus.alloc_req = 1'b0;
        check_val("live_after3", 32'(bus.num_live), 3);

        // h=1: +2 then -3 -> release pulse
        set_adj(6'd1, 9'sd2);
        @(negedge clk);
        check_val("adj_plus_err", 32'(bus.error), 0);
        check_val("adj_plus_free", 32'(bus.free_valid), 0);
        set_adj(6'd1, -9'sd3);
        @(negedge clk);
        idle_inputs();
        check_val("rel_free_valid", 32'(bus.free_valid), 1);
        check_val("rel_free_handle", 32'(bus.free_handle), 1);
        check_val("rel_num_live", 32'(bus.num_live), 2);
        check_val("rel_err", 32'(bus.error), 0);
        @(negedge clk);
        check_val("rel_pulse_end", 32'(bus.free_valid), 0);

        // Handle 0 adjust is a NOP
        set_adj(6'd0, -9'sd7);
        @(negedge clk);
        idle_inputs();
        check_val("null_err", 32'(bus.error), 0);
        check_val("null_live", 32'(bus.num_live), 2);
        check_val("null_free", 32'(bus.free_valid), 0);

        // Drain the pool: 4..63 then the recycled 1
        bus.alloc_req = 1'b1;
        for (int unsigned i = 0; i < 61; i++) begin
            check_val("drain_grant", 32'(bus.alloc_handle), (i < 60) ? 32'(i + 4) : 32'd1);
            @(negedge clk);
        end
        bus.alloc_req = 1'b0;
        check_val("empty_ready", 32'(bus.alloc_ready), 0);
        check_val("empty_handle", 32'(bus.alloc_handle), 0);
        check_val("full_live", 32'(bus.num_live), 63);

        // Release h=5 into the empty pool
        set_adj(6'd5, -9'sd1);
        @(negedge clk);
        idle_inputs();
        check_val("h5_free_valid", 32'(bus.free_valid), 1);
        check_val("h5_free_handle", 32'(bus.free_handle), 5);
        check_val("h5_ready_pending", 32'(bus.alloc_ready), 0);
        check_val("h5_live", 32'(bus.num_live), 62);
        @(negedge clk);
        check_val("h5_ready", 32'(bus.alloc_ready), 1);
        check_val("h5_head", 32'(bus.alloc_handle), 5);

        // Alloc of 5 and adjust of 5 together: adjust sees it non-live
        bus.alloc_req = 1'b1;
        set_adj(6'd5, 9'sd1);
        @(negedge clk);
        idle_inputs();
        check_val("same_err", 32'(bus.error), 1);
        check_val("same_live", 32'(bus.num_live), 63);
        check_val("same_free", 32'(bus.free_valid), 0);

        // Saturation at 255: +254, +1 (saturates), -254 leaves 1, -1 frees
        do_reset();
        check_val("sat_rst_err", 32'(bus.error), 0);
        bus.alloc_req = 1'b1;
        @(negedge clk);
        bus.alloc_req = 1'b0;
        set_adj(6'd1, 9'sd254);
        @(negedge clk);
        check_val("sat_254_err", 32'(bus.error), 0);
        set_adj(6'd1, 9'sd1);
        @(negedge clk);
        check_val("sat_err", 32'(bus.error), 0 + 1);
        set_adj(6'd1, -9'sd254);
        @(negedge clk);
        check_val("sat_no_free", 32'(bus.free_valid), 0);
        set_adj(6'd1, -9'sd1);
        @(negedge clk);
        idle_inputs();
        check_val("sat_free", 32'(bus.free_valid), 1);
        check_val("sat_free_h", 32'(bus.free_handle), 1);

        // Underflow: count 1, -2 -> error and release; then late adjust ignored
        do_reset();
        bus.alloc_req = 1'b1;
        @(negedge clk);
        bus.alloc_req = 1'b0;
        check_val("uf_live", 32'(bus.num_live), 1);
        set_adj(6'd1, -9'sd2);
        @(negedge clk);
        check_val("uf_err", 32'(bus.error), 1);
        check_val("uf_free", 32'(bus.free_valid), 1);
        check_val("uf_free_h", 32'(bus.free_handle), 1);
        check_val("uf_live0", 32'(bus.num_live), 0);
        set_adj(6'd1, 9'sd1);
        @(negedge clk);
        idle_inputs();
        check_val("late_err", 32'(bus.error), 1);
        check_val("late_free", 32'(bus.free_valid), 0);
        check_val("late_live", 32'(bus.num_live), 0);

        // Reset in the middle of an allocation burst
        do_reset();
        bus.alloc_req = 1'b1;
        repeat (5) @(negedge clk);
        check_val("mid_live5", 32'(bus.num_live), 5);
        #2;
        rst = 1'b1;
        bus.alloc_req = 1'b0;
        #1;
        check_val("mid_ready", 32'(bus.alloc_ready), 0);
        check_val("mid_handle", 32'(bus.alloc_handle), 0);
        check_val("mid_live", 32'(bus.num_live), 0);
        check_val("mid_err", 32'(bus.error), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (62) @(negedge clk);
        check_val("mid_init_ready", 32'(bus.alloc_ready), 0);
        @(negedge clk);
        check_val("mid_ready_again", 32'(bus.alloc_ready), 1);
        check_val("mid_live_before", 32'(bus.num_live), 0);
        check_val("mid_first_grant", 32'(bus.alloc_handle), 1);
        bus.alloc_req = 1'b1;
        @(negedge clk);
        bus.alloc_req = 1'b0;
        check_val("mid_live_after", 32'(bus.num_live), 1);
        check_val("mid_next_head", 32'(bus.alloc_handle), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
